// File: rtl/unified_mem_responder.sv
// unified_mem_responder
//   Memory-side responder for the shared instruction/data memory of the
//   pipelined RV32IMC core. It holds a byte-addressed, little-endian store of
//   2^MEM_ADDR bytes. It serves one request at a time through valid/ready
//   handshakes. Each response comes a fixed LAT cycles after the request is
//   accepted.
//
//   Data requests win over fetch requests. Fetches may sit on any halfword
//   boundary, so a compressed instruction can be returned in the low half of
//   the response word.
//
//   This block assumes N = 32: loads, stores and fetches move at most four
//   bytes.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   if_req_valid/ready, if_addr
//                     fetch request handshake and byte address
//   d_req_valid/ready, d_addr, d_read, d_write, d_wdata
//                     data request handshake, byte address, load type
//                     (1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU), store type
//                     (1 SB, 2 SH, 3 SW) and store data
//   rsp_valid/ready   response handshake
//   rsp_data          load/fetch result (0 for stores and errors)
//   rsp_src           0 = fetch response, 1 = data response
//   rsp_err           misaligned or illegal request
//   rsp_is_comp       fetch returned a 16-bit (compressed) instruction
module unified_mem_responder #(
  parameter int MEM_ADDR = 8,
  parameter int N        = 32,
  parameter int LAT      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [MEM_ADDR-1:0] if_addr,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [MEM_ADDR-1:0] d_addr,
  input  logic [2:0]          d_read,
  input  logic [1:0]          d_write,
  input  logic [N-1:0]        d_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [N-1:0]        rsp_data,
  output logic                rsp_src,
  output logic                rsp_err,
  output logic                rsp_is_comp
);

  localparam int DEPTH = 1 << MEM_ADDR;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] mem [DEPTH];

  logic d_acc, if_acc, acc;
  logic [MEM_ADDR-1:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;
  logic d_err, f_err, sel_err;
  logic [N-1:0] ld_data, rsp_data_nxt;

  // Readies are only offered in IDLE and never during reset. A fetch is held
  // off whenever a data request is pending, so the two ports cannot be
  // accepted in the same cycle.
  assign d_req_ready  = rst && (state == IDLE);
  assign if_req_ready = d_req_ready && !d_req_valid;
  assign d_acc        = d_req_valid && d_req_ready;
  assign if_acc       = if_req_valid && if_req_ready;
  assign acc          = d_acc || if_acc;
  assign rsp_valid    = (state == RESP);

  // Four consecutive byte addresses. Each one wraps modulo the memory size,
  // so a fetch near the top of memory continues at address 0.
  assign a0 = d_req_valid ? d_addr : if_addr;
  assign a1 = a0 + MEM_ADDR'(1);
  assign a2 = a0 + MEM_ADDR'(2);
  assign a3 = a0 + MEM_ADDR'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  // Classify the data request as illegal when any of these holds:
  //   - the load code is unknown (6 or 7);
  //   - both a load and a store are requested;
  //   - neither a load nor a store is requested;
  //   - the access is misaligned for its size.
  assign d_err = (d_read > 3'd5)
              || (d_read != 3'd0 && d_write != 2'd0)
              || (d_read == 3'd0 && d_write == 2'd0)
              || ((d_read == 3'd2 || d_read == 3'd5 || d_write == 2'd2) && d_addr[0])
              || ((d_read == 3'd3 || d_write == 2'd3) && d_addr[1:0] != 2'b00);
  assign f_err   = if_addr[0];
  assign sel_err = d_req_valid ? d_err : f_err;

  // Shape the load result. Signed loads extend the top bit of the loaded
  // byte or halfword. Unsigned loads and LW fill the upper bits with zeros.
  always_comb begin
    ld_data = '0;
    case (d_read)
      3'd1:    ld_data = N'($signed(b0));
      3'd2:    ld_data = N'($signed({b1, b0}));
      3'd3:    ld_data = N'({b3, b2, b1, b0});
      3'd4:    ld_data = N'(b0);
      3'd5:    ld_data = N'({b1, b0});
      default: ld_data = '0;
    endcase
  end

  // Choose what the response will carry. Errors and stores return zero. A
  // fetch returns the four bytes starting at its address.
  always_comb begin
    rsp_data_nxt = '0;
    if (!sel_err) begin
      if (d_req_valid) rsp_data_nxt = ld_data;
      else             rsp_data_nxt = N'({b3, b2, b1, b0});
    end
  end

  // State and latency counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. A request accepted at edge E becomes visible as
  // rsp_valid after edge E+LAT. For LAT > 1 that means LAT-1 counting steps
  // in WAIT, plus the final step into RESP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (acc) begin
          cnt_nxt   = 4'(LAT - 1);
          state_nxt = (LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response fields are captured at the accept edge. They then stay constant
  // through WAIT and RESP until the next request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data    <= '0;
      rsp_src     <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_is_comp <= 1'b0;
    end else if (acc) begin
      rsp_data    <= rsp_data_nxt;
      rsp_src     <= d_acc;
      rsp_err     <= sel_err;
      rsp_is_comp <= !d_acc && (rsp_data_nxt[1:0] != 2'b11);
    end
  end

  // Stores commit at the accept edge, so the very next read sees them.
  // Storage has no reset, so a committed write survives a later reset.
  always_ff @(posedge clk) begin
    if (d_acc && !d_err) begin
      case (d_write)
        2'd1: mem[a0] <= d_wdata[7:0];
        2'd2: begin
          mem[a0] <= d_wdata[7:0];
          mem[a1] <= d_wdata[15:8];
        end
        2'd3: begin
          mem[a0] <= d_wdata[7:0];
          mem[a1] <= d_wdata[15:8];
          mem[a2] <= d_wdata[23:16];
          mem[a3] <= d_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_responder.sv
module tb_unified_mem_responder;
  localparam int MEM_ADDR = 8;
  localparam int N        = 32;
  localparam int LAT      = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                if_req_valid = 1'b0;
  logic                if_req_ready;
  logic [MEM_ADDR-1:0] if_addr = '0;
  logic                d_req_valid = 1'b0;
  logic                d_req_ready;
  logic [MEM_ADDR-1:0] d_addr = '0;
  logic [2:0]          d_read = '0;
  logic [1:0]          d_write = '0;
  logic [N-1:0]        d_wdata = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [N-1:0]        rsp_data;
  logic                rsp_src;
  logic                rsp_err;
  logic                rsp_is_comp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] r_data;
  logic        r_src, r_err, r_comp;
  int          r_lat;

  unified_mem_responder #(.MEM_ADDR(MEM_ADDR), .N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_src(rsp_src), .rsp_err(rsp_err), .rsp_is_comp(rsp_is_comp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one request and waits for its response, then completes the
  // handshake. lat is the number of edges from accept to rsp_valid, or 99 if
  // no response arrived.
  task automatic issue(input bit is_d, input logic [7:0] addr, input logic [2:0] rd,
                       input logic [1:0] wr, input logic [31:0] wd,
                       output logic [31:0] data, output logic src, output logic err,
                       output logic comp, output int lat);
    int guard;
    @(negedge clk);
    if (is_d) begin
      d_req_valid = 1'b1; d_addr = addr; d_read = rd; d_write = wr; d_wdata = wd;
    end else begin
      if_req_valid = 1'b1; if_addr = addr;
    end
    #1;
    guard = 0;
    while (!(is_d ? d_req_ready : if_req_ready) && guard < 20) begin
      @(negedge clk); guard++;
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0; if_req_valid = 1'b0; d_read = '0; d_write = '0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!rsp_valid && lat < 20);
    if (!rsp_valid) lat = 99;
    data = rsp_data; src = rsp_src; err = rsp_err; comp = rsp_is_comp;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (d_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_d_ready: got %b expected 0", d_req_ready); end
    n_checks++; if (if_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_if_ready: got %b expected 0", if_req_ready); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    n_checks++; if ({rsp_err, rsp_src, rsp_is_comp} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {rsp_err, rsp_src, rsp_is_comp}); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (d_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_d_ready: got %b expected 1", d_req_ready); end
    n_checks++; if (if_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_if_ready: got %b expected 1", if_req_ready); end
  endtask

  task automatic test_fetch_basic();
    issue(1'b1, 8'h00, 3'd0, 2'd3, 32'h00100513, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_data !== 32'h0 || r_err !== 1'b0 || r_src !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_0x00: got data %h err %b src %b expected 0/0/1", r_data, r_err, r_src); end
    n_checks++; if (r_lat !== LAT) begin n_fail++; $display("[TB] FAIL sw_latency: got %0d expected %0d", r_lat, LAT); end
    issue(1'b0, 8'h00, 3'd0, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_data !== 32'h00100513) begin n_fail++; $display("[TB] FAIL fetch_0x00_data: got %h expected 00100513", r_data); end
    n_checks++; if ({r_src, r_err, r_comp} !== 3'b000) begin n_fail++; $display("[TB] FAIL fetch_0x00_flags: got %b expected 000", {r_src, r_err, r_comp}); end
    n_checks++; if (r_lat !== LAT) begin n_fail++; $display("[TB] FAIL fetch_latency: got %0d expected %0d", r_lat, LAT); end
  endtask

  task automatic test_loads();
    issue(1'b1, 8'h40, 3'd0, 2'd3, 32'hDEADBEEF, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_0x40_err: got %b expected 0", r_err); end
    issue(1'b1, 8'h43, 3'd1, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_data !== 32'hFFFFFFDE || r_src !== 1'b1 || r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL lb_0x43: got %h src %b err %b expected FFFFFFDE/1/0", r_data, r_src, r_err); end
    issue(1'b1, 8'h43, 3'd4, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_data !== 32'h000000DE || r_src !== 1'b1 || r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL lbu_0x43: got %h src %b err %b expected 000000DE/1/0", r_data, r_src, r_err); end
    issue(1'b1, 8'h42, 3'd2, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_data !== 32'hFFFFDEAD || r_src !== 1'b1 || r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL lh_0x42: got %h src %b err %b expected FFFFDEAD/1/0", r_data, r_src, r_err); end
    issue(1'b1, 8'h40, 3'd5, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_data !== 32'h0000BEEF) begin n_fail++; $display("[TB] FAIL lhu_0x40: got %h expected 0000BEEF", r_data); end
    issue(1'b1, 8'h40, 3'd3, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_data !== 32'hDEADBEEF || r_comp !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_0x40: got %h comp %b expected DEADBEEF/0", r_data, r_comp); end
  endtask

  task automatic test_arbitration();
    int guard;
    @(negedge clk);
    d_req_valid = 1'b1; d_addr = 8'h40; d_read = 3'd3; d_write = 2'd0;
    if_req_valid = 1'b1; if_addr = 8'h00;
    #1;
    n_checks++; if (if_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL arb_if_ready: got %b expected 0", if_req_ready); end
    n_checks++; if (d_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL arb_d_ready: got %b expected 1", d_req_ready); end
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_read = '0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      n_checks++; if (if_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL arb_if_ready_wait: got %b expected 0", if_req_ready); end
      @(posedge clk); #1; guard++;
    end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_src !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL arb_first_rsp: got valid %b src %b data %h expected 1/1/DEADBEEF", rsp_valid, rsp_src, rsp_data); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++; if (if_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL arb_if_ready_after: got %b expected 1", if_req_ready); end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    r_lat = 0;
    do begin @(posedge clk); #1; r_lat++; end while (!rsp_valid && r_lat < 20);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_src !== 1'b0 || rsp_data !== 32'h00100513 || r_lat !== LAT) begin n_fail++; $display("[TB] FAIL arb_fetch_rsp: got valid %b src %b data %h lat %0d expected 1/0/00100513/%0d", rsp_valid, rsp_src, rsp_data, r_lat, LAT); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clk);
    d_req_valid = 1'b1; d_addr = 8'h40; d_read = 3'd3; d_write = 2'd0;
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_read = '0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_src !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_rsp_%0d: got valid %b data %h src %b err %b expected 1/DEADBEEF/1/0", i, rsp_valid, rsp_data, rsp_src, rsp_err); end
      n_checks++; if (d_req_ready !== 1'b0 || if_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_ready_%0d: got %b%b expected 00", i, d_req_ready, if_req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || d_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_idle: got valid %b d_ready %b expected 0/1", rsp_valid, d_req_ready); end
  endtask

  task automatic test_errors();
    issue(1'b1, 8'h41, 3'd3, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_err !== 1'b1 || r_data !== 32'h0 || r_src !== 1'b1 || r_lat !== LAT) begin n_fail++; $display("[TB] FAIL err_lw_0x41: got err %b data %h src %b lat %0d expected 1/0/1/%0d", r_err, r_data, r_src, r_lat, LAT); end
    issue(1'b1, 8'h43, 3'd0, 2'd2, 32'h00001234, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_err !== 1'b1 || r_data !== 32'h0) begin n_fail++; $display("[TB] FAIL err_sh_0x43: got err %b data %h expected 1/0", r_err, r_data); end
    issue(1'b1, 8'h40, 3'd7, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_err !== 1'b1 || r_data !== 32'h0) begin n_fail++; $display("[TB] FAIL err_read7: got err %b data %h expected 1/0", r_err, r_data); end
    issue(1'b1, 8'h40, 3'd3, 2'd3, 32'h55555555, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_err !== 1'b1 || r_data !== 32'h0) begin n_fail++; $display("[TB] FAIL err_rd_and_wr: got err %b data %h expected 1/0", r_err, r_data); end
    issue(1'b1, 8'h40, 3'd0, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_no_op: got err %b expected 1", r_err); end
    issue(1'b0, 8'h01, 3'd0, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_err !== 1'b1 || r_src !== 1'b0 || r_data !== 32'h0) begin n_fail++; $display("[TB] FAIL err_fetch_odd: got err %b src %b data %h expected 1/0/0", r_err, r_src, r_data); end
    issue(1'b1, 8'h40, 3'd3, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_data !== 32'hDEADBEEF || r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_readback: got %h err %b expected DEADBEEF/0", r_data, r_err); end
  endtask

  task automatic test_fetch_wrap();
    issue(1'b1, 8'hFE, 3'd0, 2'd2, 32'h00004501, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL sh_0xfe_err: got %b expected 0", r_err); end
    issue(1'b0, 8'hFE, 3'd0, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_data !== 32'h05134501) begin n_fail++; $display("[TB] FAIL fetch_wrap_data: got %h expected 05134501", r_data); end
    n_checks++; if (r_comp !== 1'b1 || r_src !== 1'b0 || r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_wrap_flags: got comp %b src %b err %b expected 1/0/0", r_comp, r_src, r_err); end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    @(negedge clk);
    d_req_valid = 1'b1; d_addr = 8'h80; d_read = 3'd0; d_write = 2'd3; d_wdata = 32'h11223344;
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_write = '0;
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rsp_valid !== 1'b0 || d_req_ready !== 1'b0 || if_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_%0d: got valid %b readies %b%b expected 0/00", i, rsp_valid, d_req_ready, if_req_ready); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL midrst_no_rsp: got %0d responses expected 0", seen); end
    issue(1'b1, 8'h80, 3'd3, 2'd0, 32'h0, r_data, r_src, r_err, r_comp, r_lat);
    n_checks++; if (r_data !== 32'h11223344 || r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_write_kept: got %h err %b expected 11223344/0", r_data, r_err); end
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_loads();
    test_arbitration();
    test_backpressure();
    test_errors();
    test_fetch_wrap();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
